// File: rtl/rom16x4_pkg.sv
// Shared definitions for the 16x4 constant table and its reverse lookup.
// The optional MATCH_COUNT_EN build flag is consumed by rom16x4_rev_lookup.
package rom16x4_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 4;

    // Entry 0 sits in the least significant nibble.
    localparam logic [63:0] ROM_DATA = 64'h6AE8_D31F_0C17_A92C;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [DEF_DATA_W-1:0] rom_entry(input logic [DEF_ADDR_W-1:0] idx);
        return ROM_DATA[{idx, 2'b00} +: DEF_DATA_W];
    endfunction

endpackage

// File: rtl/rom16x4_table.sv
// Combinational index-to-data view of the shared 16x4 constant table,
// usable by both the forward and the reverse lookup.
module rom16x4_table
    import rom16x4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] index,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rom_entry(index);
    end

endmodule

// File: rtl/rom16x4_rev_lookup.sv
// Reverse lookup: scans the 16x4 table one entry per clock for a value.
// Define MATCH_COUNT_EN for a full 16-entry scan plus a match_count output.
module rom16x4_rev_lookup
    import rom16x4_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] address
`ifdef MATCH_COUNT_EN
    ,
    output logic [ADDR_W:0]   match_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              found_q, found_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] entry;
    logic              hit;

`ifdef MATCH_COUNT_EN
    logic              hit_seen_q, hit_seen_d;
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
`endif

    rom16x4_table #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_table (
        .index(index_q),
        .data (entry)
    );

    assign hit = (entry == value_q);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        value_d   = value_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        found_d   = found_q;
        address_d = address_q;
`ifdef MATCH_COUNT_EN
        hit_seen_d = hit_seen_q;
        hit_addr_d = hit_addr_q;
        count_d    = count_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    index_d = '0;
                    value_d = value;
                    busy_d  = 1'b1;
`ifdef MATCH_COUNT_EN
                    hit_seen_d = 1'b0;
                    hit_addr_d = '0;
                    count_d    = '0;
`endif
                end
            end
            SCAN: begin
`ifdef MATCH_COUNT_EN
                count_d = count_q + (ADDR_W+1)'(hit);
                if (hit && !hit_seen_q) begin
                    hit_seen_d = 1'b1;
                    hit_addr_d = index_q;
                end
                if (index_q == LAST_INDEX) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    found_d   = hit_seen_d;
                    address_d = hit_seen_d ? hit_addr_d : '0;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
`else
                if (hit || index_q == LAST_INDEX) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    found_d   = hit;
                    address_d = hit ? index_q : '0;
                end else begin
                    index_d = index_q + ADDR_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            value_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            address_q <= '0;
`ifdef MATCH_COUNT_EN
            hit_seen_q <= 1'b0;
            hit_addr_q <= '0;
            count_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            value_q   <= value_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            address_q <= address_d;
`ifdef MATCH_COUNT_EN
            hit_seen_q <= hit_seen_d;
            hit_addr_q <= hit_addr_d;
            count_q    <= count_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign found   = found_q;
    assign address = address_q;
`ifdef MATCH_COUNT_EN
    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_rom16x4_rev_lookup.sv
// Directed bench for rom16x4_rev_lookup; expectations follow MATCH_COUNT_EN
// when it is defined for the whole compile.
module tb_rom16x4_rev_lookup;

`ifdef MATCH_COUNT_EN
    localparam bit FULL_SCAN = 1'b1;
`else
    localparam bit FULL_SCAN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] value;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] address;
`ifdef MATCH_COUNT_EN
    logic [4:0] match_count;
`endif

    int checks = 0;
    int errors = 0;

    rom16x4_rev_lookup dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .address(address)
`ifdef MATCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done is seen; edges counts clocks since the accepting edge, -1 on timeout.
    task automatic wait_done(input int start_edges, output int edges);
        edges = start_edges;
        while (done !== 1'b1 && edges < 40) begin
            step();
            edges++;
        end
        if (done !== 1'b1) edges = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        value = 4'h0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
        checks++; if (found !== 1'b0) begin errors++; $display("[TB] FAIL reset_found: got %0b expected 0", found); end
        checks++; if (address !== 4'h0) begin errors++; $display("[TB] FAIL reset_address: got %0h expected 0", address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", match_count); end
`endif
        rst_n = 1'b1;
        step();
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL idle_no_start: got busy %0b done %0b expected 0 0", busy, done); end
    endtask

    task automatic test_first_entry();
        int edges;
        value = 4'hC;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %0b expected 1", busy); end
        wait_done(0, edges);
        checks++; if (edges !== (FULL_SCAN ? 16 : 1)) begin errors++; $display("[TB] FAIL first_latency: got %0d expected %0d", edges, FULL_SCAN ? 16 : 1); end
        checks++; if (found !== 1'b1 || address !== 4'h0) begin errors++; $display("[TB] FAIL first_result: got found %0b addr %0h expected 1 0", found, address); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL first_busy_at_done: got %0b expected 0", busy); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd2) begin errors++; $display("[TB] FAIL first_count: got %0d expected 2", match_count); end
`endif
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL first_done_pulse: got %0b expected 0", done); end
        checks++; if (found !== 1'b1 || address !== 4'h0) begin errors++; $display("[TB] FAIL first_hold: got found %0b addr %0h expected 1 0", found, address); end
    endtask

    task automatic test_last_entry();
        int edges;
        value = 4'h6;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, edges);
        checks++; if (edges !== 16) begin errors++; $display("[TB] FAIL last_latency: got %0d expected 16", edges); end
        checks++; if (found !== 1'b1 || address !== 4'hF) begin errors++; $display("[TB] FAIL last_result: got found %0b addr %0h expected 1 f", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd1) begin errors++; $display("[TB] FAIL last_count: got %0d expected 1", match_count); end
`endif
        step();
    endtask

    task automatic test_absent();
        int edges;
        value = 4'h4;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++; if (found !== 1'b1 || address !== 4'hF) begin errors++; $display("[TB] FAIL absent_prev_held: got found %0b addr %0h expected 1 f", found, address); end
        wait_done(0, edges);
        checks++; if (edges !== 16) begin errors++; $display("[TB] FAIL absent_latency: got %0d expected 16", edges); end
        checks++; if (found !== 1'b0 || address !== 4'h0) begin errors++; $display("[TB] FAIL absent_result: got found %0b addr %0h expected 0 0", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd0) begin errors++; $display("[TB] FAIL absent_count: got %0d expected 0", match_count); end
`endif
        step();
    endtask

    task automatic test_ignored_inputs();
        int edges;
        value = 4'h1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        value = 4'h6;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3, edges);
        checks++; if (edges !== (FULL_SCAN ? 16 : 6)) begin errors++; $display("[TB] FAIL ignored_latency: got %0d expected %0d", edges, FULL_SCAN ? 16 : 6); end
        checks++; if (found !== 1'b1 || address !== 4'h5) begin errors++; $display("[TB] FAIL ignored_result: got found %0b addr %0h expected 1 5", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd2) begin errors++; $display("[TB] FAIL ignored_count: got %0d expected 2", match_count); end
`endif
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL ignored_no_requeue: got busy %0b done %0b expected 0 0", busy, done); end
    endtask

    task automatic test_back_to_back();
        int edges;
        value = 4'hA;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(0, edges);
        checks++; if (edges !== (FULL_SCAN ? 16 : 4)) begin errors++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", edges, FULL_SCAN ? 16 : 4); end
        checks++; if (found !== 1'b1 || address !== 4'h3) begin errors++; $display("[TB] FAIL b2b_first_result: got found %0b addr %0h expected 1 3", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd2) begin errors++; $display("[TB] FAIL b2b_first_count: got %0d expected 2", match_count); end
`endif
        start = 1'b1;
        value = 4'h2;
        step();
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_accept: got busy %0b done %0b expected 1 0", busy, done); end
        wait_done(0, edges);
        checks++; if (edges !== (FULL_SCAN ? 16 : 2)) begin errors++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", edges, FULL_SCAN ? 16 : 2); end
        checks++; if (found !== 1'b1 || address !== 4'h1) begin errors++; $display("[TB] FAIL b2b_second_result: got found %0b addr %0h expected 1 1", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd1) begin errors++; $display("[TB] FAIL b2b_second_count: got %0d expected 1", match_count); end
`endif
        step();
    endtask

    task automatic test_reset_mid_scan();
        int done_seen;
        value = 4'hB;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst_n = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_ctrl: got busy %0b done %0b expected 0 0", busy, done); end
        checks++; if (found !== 1'b0 || address !== 4'h0) begin errors++; $display("[TB] FAIL midreset_result: got found %0b addr %0h expected 0 0", found, address); end
`ifdef MATCH_COUNT_EN
        checks++; if (match_count !== 5'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", match_count); end
`endif
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL midreset_no_done: got %0d active cycles expected 0", done_seen); end
    endtask

    initial begin
        test_reset();
        test_first_entry();
        test_last_entry();
        test_absent();
        test_ignored_inputs();
        test_back_to_back();
        test_reset_mid_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
